// File: rtl/decode_pipe_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_pipe_stage_if
// Description : Bundle of instruction, writeback, EX-hazard and ID/EX signals
//               for the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_pipe_stage_if #(
    parameter int DATA_W = 32,
    parameter int AW     = 5,
    parameter int CTRL_W = 20
);
    logic              in_valid;
    logic [31:0]       in_instr;
    logic [DATA_W-1:0] in_pc4;
    logic [CTRL_W-1:0] in_ctrl;
    logic              in_zext;
    logic              in_link;
    logic              wb_we;
    logic [AW-1:0]     wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              ex_valid;
    logic              ex_memread;
    logic [AW-1:0]     ex_rt;
    logic              flush;
    logic              stall_req;
    logic              out_valid;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_rs_data;
    logic [DATA_W-1:0] out_rt_data;
    logic [DATA_W-1:0] out_imm;
    logic [DATA_W-1:0] out_pc4;
    logic [DATA_W-1:0] out_jaddr;
    logic [AW-1:0]     out_rs;
    logic [AW-1:0]     out_rt;
    logic [AW-1:0]     out_rd;

    modport master (
        output in_valid, in_instr, in_pc4, in_ctrl, in_zext, in_link,
               wb_we, wb_addr, wb_data, ex_valid, ex_memread, ex_rt, flush,
        input  stall_req, out_valid, out_ctrl, out_rs_data, out_rt_data,
               out_imm, out_pc4, out_jaddr, out_rs, out_rt, out_rd
    );

    modport slave (
        input  in_valid, in_instr, in_pc4, in_ctrl, in_zext, in_link,
               wb_we, wb_addr, wb_data, ex_valid, ex_memread, ex_rt, flush,
        output stall_req, out_valid, out_ctrl, out_rs_data, out_rt_data,
               out_imm, out_pc4, out_jaddr, out_rs, out_rt, out_rd
    );
endinterface
`default_nettype wire

// File: rtl/decode_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_pipe_stage
// Description : ID stage - register file with bypass, pending link buffer,
//               load-use stall and ID/EX pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_pipe_stage #(
    parameter int DATA_W   = 32,
    parameter int AW       = 5,
    parameter int CTRL_W   = 20,
    parameter int LINK_REG = 31
) (
    input  wire logic           Clk,
    input  wire logic           Reset,
    decode_pipe_stage_if.slave  bus
);
    localparam int          c_NREGS = 2**AW;
    localparam logic [AW-1:0] c_LINK = AW'(LINK_REG);

    logic [DATA_W-1:0] r_regs [c_NREGS];
    logic              r_pendValid;
    logic [DATA_W-1:0] r_pendData;

    logic [AW-1:0]     w_rs;
    logic [AW-1:0]     w_rt;
    logic [AW-1:0]     w_rd;
    logic [15:0]       w_imm;
    logic [DATA_W-1:0] w_linkVal;
    logic              w_loadUse;
    logic              w_linkStall;
    logic              w_stall;
    logic              w_bubble;
    logic              w_linkAccept;
    logic              w_pendLoad;
    logic              w_we;
    logic [AW-1:0]     w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rsData;
    logic [DATA_W-1:0] w_rtData;
    logic [DATA_W-1:0] w_immExt;

    assign w_rs      = AW'(bus.in_instr[25:21]);
    assign w_rt      = AW'(bus.in_instr[20:16]);
    assign w_rd      = AW'(bus.in_instr[15:11]);
    assign w_imm     = bus.in_instr[15:0];
    assign w_linkVal = bus.in_pc4 + DATA_W'(4);

    assign w_loadUse   = bus.in_valid && bus.ex_valid && bus.ex_memread &&
                         (bus.ex_rt != '0) && ((bus.ex_rt == w_rs) || (bus.ex_rt == w_rt));
    assign w_linkStall = bus.in_valid && bus.in_link && r_pendValid && bus.wb_we;
    assign w_stall     = w_loadUse || w_linkStall;
    assign w_bubble    = w_stall || bus.flush;

    assign bus.stall_req = !Reset && w_stall;

    assign w_linkAccept = bus.in_valid && bus.in_link && !w_bubble;
    // A link that cannot own the write port this cycle (wb busy, or an older
    // pending link draining) parks in the buffer so link order is preserved.
    assign w_pendLoad   = w_linkAccept && (bus.wb_we || r_pendValid);

    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        if (bus.wb_we) begin
            w_we    = 1'b1;
            w_waddr = bus.wb_addr;
            w_wdata = bus.wb_data;
        end else if (r_pendValid) begin
            w_we    = 1'b1;
            w_waddr = c_LINK;
            w_wdata = r_pendData;
        end else if (w_linkAccept) begin
            w_we    = 1'b1;
            w_waddr = c_LINK;
            w_wdata = w_linkVal;
        end
    end

    function automatic logic [DATA_W-1:0] readPort(input logic [AW-1:0] a);
        if (a == '0)
            return '0;
        else if (bus.wb_we && (bus.wb_addr == a))
            return bus.wb_data;
        else if (r_pendValid && (a == c_LINK))
            return r_pendData;
        else
            return r_regs[a];
    endfunction

    assign w_rsData = readPort(w_rs);
    assign w_rtData = readPort(w_rt);
    assign w_immExt = bus.in_zext ? {{(DATA_W-16){1'b0}}, w_imm}
                                  : {{(DATA_W-16){w_imm[15]}}, w_imm};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < c_NREGS; i++) r_regs[i] <= '0;
            r_pendValid <= 1'b0;
            r_pendData  <= '0;
        end else begin
            if (w_we && (w_waddr != '0)) r_regs[w_waddr] <= w_wdata;
            if (w_pendLoad) begin
                r_pendValid <= 1'b1;
                r_pendData  <= w_linkVal;
            end else if (r_pendValid && !bus.wb_we) begin
                r_pendValid <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset || w_bubble) begin
            bus.out_valid   <= 1'b0;
            bus.out_ctrl    <= '0;
            bus.out_rs_data <= '0;
            bus.out_rt_data <= '0;
            bus.out_imm     <= '0;
            bus.out_pc4     <= '0;
            bus.out_jaddr   <= '0;
            bus.out_rs      <= '0;
            bus.out_rt      <= '0;
            bus.out_rd      <= '0;
        end else begin
            bus.out_valid   <= bus.in_valid;
            bus.out_ctrl    <= bus.in_valid ? bus.in_ctrl : '0;
            bus.out_rs_data <= w_rsData;
            bus.out_rt_data <= w_rtData;
            bus.out_imm     <= w_immExt;
            bus.out_pc4     <= bus.in_pc4;
            bus.out_jaddr   <= {bus.in_pc4[DATA_W-1:28], bus.in_instr[25:0], 2'b00};
            bus.out_rs      <= w_rs;
            bus.out_rt      <= w_rt;
            bus.out_rd      <= w_rd;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_decode_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_pipe_stage
// Description : Directed self-checking bench for decode_pipe_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_pipe_stage;
    logic Clk;
    logic Reset;
    int   nAsserts;
    int   nFails;

    decode_pipe_stage_if #(.DATA_W(32), .AW(5), .CTRL_W(20)) bus ();

    decode_pipe_stage #(
        .DATA_W(32), .AW(5), .CTRL_W(20), .LINK_REG(31)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nAsserts++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [15:0] imm);
        return {6'd0, rs, rt, imm};
    endfunction

    task automatic idle();
        bus.in_valid   = 1'b0;
        bus.in_instr   = '0;
        bus.in_pc4     = '0;
        bus.in_ctrl    = '0;
        bus.in_zext    = 1'b0;
        bus.in_link    = 1'b0;
        bus.wb_we      = 1'b0;
        bus.wb_addr    = '0;
        bus.wb_data    = '0;
        bus.ex_valid   = 1'b0;
        bus.ex_memread = 1'b0;
        bus.ex_rt      = '0;
        bus.flush      = 1'b0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        bus.wb_we   = 1'b1;
        bus.wb_addr = a;
        bus.wb_data = d;
    endtask

    task automatic link(input logic [31:0] pc4);
        bus.in_valid = 1'b1;
        bus.in_link  = 1'b1;
        bus.in_pc4   = pc4;
        bus.in_ctrl  = 20'h1;
        bus.in_instr = mk(5'd0, 5'd0, 16'h0);
    endtask

    initial begin
        nAsserts = 0;
        nFails   = 0;
        Reset    = 1'b1;
        idle();
        bus.in_valid = 1'b1; bus.in_instr = mk(5'd0, 5'd8, 16'h0);
        bus.ex_valid = 1'b1; bus.ex_memread = 1'b1; bus.ex_rt = 5'd8;
        #2 check("rst_stall", 64'(bus.stall_req), 64'd0);
        tick();
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_ctrl",  64'(bus.out_ctrl), 64'd0);
        check("rst_pc4",   64'(bus.out_pc4), 64'd0);
        Reset = 1'b0;
        idle();

        // Same-cycle writeback bypass, sign-extend and jump address
        wb(5'd5, 32'hDEADBEEF);
        bus.in_valid = 1'b1; bus.in_instr = mk(5'd5, 5'd6, 16'h8001);
        bus.in_pc4 = 32'hF000_0200; bus.in_ctrl = 20'h12345;
        tick();
        check("byp_rs",   64'(bus.out_rs_data), 64'hDEADBEEF);
        check("byp_valid",64'(bus.out_valid), 64'd1);
        check("byp_ctrl", 64'(bus.out_ctrl), 64'h12345);
        check("sext_imm", 64'(bus.out_imm), 64'hFFFF8001);
        check("jaddr",    64'(bus.out_jaddr), 64'hF29A0004);
        check("pc4",      64'(bus.out_pc4), 64'hF0000200);
        check("fld_rs",   64'(bus.out_rs), 64'd5);
        check("fld_rt",   64'(bus.out_rt), 64'd6);
        check("fld_rd",   64'(bus.out_rd), 64'h10);
        idle();
        bus.in_valid = 1'b1; bus.in_instr = mk(5'd5, 5'd0, 16'h8001); bus.in_zext = 1'b1;
        tick();
        check("rf_rs",    64'(bus.out_rs_data), 64'hDEADBEEF);
        check("r0_rt",    64'(bus.out_rt_data), 64'd0);
        check("zext_imm", 64'(bus.out_imm), 64'h00008001);

        // Load-use hazard
        idle();
        bus.in_valid = 1'b1; bus.in_instr = mk(5'd0, 5'd8, 16'h0); bus.in_ctrl = 20'h55;
        bus.ex_valid = 1'b1; bus.ex_memread = 1'b1; bus.ex_rt = 5'd8;
        #1 check("lu_stall_rt", 64'(bus.stall_req), 64'd1);
        tick();
        check("lu_valid", 64'(bus.out_valid), 64'd0);
        check("lu_ctrl",  64'(bus.out_ctrl), 64'd0);
        bus.ex_rt = 5'd0; bus.in_instr = mk(5'd0, 5'd0, 16'h0);
        #1 check("lu_rt0", 64'(bus.stall_req), 64'd0);
        bus.ex_rt = 5'd8; bus.in_instr = mk(5'd8, 5'd1, 16'h0);
        #1 check("lu_stall_rs", 64'(bus.stall_req), 64'd1);
        bus.ex_memread = 1'b0;
        #1 check("lu_nomem", 64'(bus.stall_req), 64'd0);
        tick();
        check("lu_pass_valid", 64'(bus.out_valid), 64'd1);
        check("lu_pass_ctrl",  64'(bus.out_ctrl), 64'h55);

        // Link collides with writeback
        idle();
        link(32'h100); wb(5'd3, 32'h33);
        #1 check("lk_nostall", 64'(bus.stall_req), 64'd0);
        tick();
        check("lk_valid", 64'(bus.out_valid), 64'd1);
        idle();
        bus.in_valid = 1'b1; bus.in_instr = mk(5'd31, 5'd3, 16'h0); wb(5'd4, 32'h40);
        tick();
        check("lk_pend_r31", 64'(bus.out_rs_data), 64'h104);
        check("lk_r3",       64'(bus.out_rt_data), 64'h33);
        idle();
        tick();
        bus.in_valid = 1'b1; bus.in_instr = mk(5'd31, 5'd4, 16'h0); wb(5'd9, 32'h99);
        tick();
        check("lk_commit_r31", 64'(bus.out_rs_data), 64'h104);
        check("lk_r4",         64'(bus.out_rt_data), 64'h40);

        // Second link while buffer is full
        idle();
        link(32'h200); wb(5'd4, 32'h44);
        tick();
        link(32'h300); wb(5'd5, 32'h55);
        #1 check("dbl_stall1", 64'(bus.stall_req), 64'd1);
        tick();
        check("dbl_bubble", 64'(bus.out_valid), 64'd0);
        wb(5'd6, 32'h66);
        #1 check("dbl_stall2", 64'(bus.stall_req), 64'd1);
        tick();
        bus.wb_we = 1'b0;
        #1 check("dbl_drain", 64'(bus.stall_req), 64'd0);
        tick();
        check("dbl_acc_valid", 64'(bus.out_valid), 64'd1);
        check("dbl_acc_pc4",   64'(bus.out_pc4), 64'h300);
        idle();
        bus.in_valid = 1'b1; bus.in_instr = mk(5'd31, 5'd5, 16'h0); wb(5'd7, 32'h70);
        tick();
        check("dbl_pend_r31", 64'(bus.out_rs_data), 64'h304);
        check("dbl_r5",       64'(bus.out_rt_data), 64'h55);
        idle();
        tick();
        bus.in_valid = 1'b1; bus.in_instr = mk(5'd31, 5'd6, 16'h0);
        tick();
        check("dbl_r31", 64'(bus.out_rs_data), 64'h304);
        check("dbl_r6",  64'(bus.out_rt_data), 64'h66);

        // Flush with stall, then flush alone, on link instructions
        idle();
        link(32'h500); bus.in_instr = mk(5'd0, 5'd8, 16'h0); bus.in_ctrl = 20'h7;
        bus.ex_valid = 1'b1; bus.ex_memread = 1'b1; bus.ex_rt = 5'd8; bus.flush = 1'b1;
        #1 check("fl_stall", 64'(bus.stall_req), 64'd1);
        tick();
        check("fl_valid", 64'(bus.out_valid), 64'd0);
        check("fl_ctrl",  64'(bus.out_ctrl), 64'd0);
        check("fl_pc4",   64'(bus.out_pc4), 64'd0);
        idle();
        link(32'h700); bus.flush = 1'b1;
        tick();
        check("fl2_valid", 64'(bus.out_valid), 64'd0);
        idle();
        bus.in_valid = 1'b1; bus.in_instr = mk(5'd31, 5'd7, 16'h0);
        tick();
        check("fl_no_link", 64'(bus.out_rs_data), 64'h304);
        check("fl_r7",      64'(bus.out_rt_data), 64'h70);

        // Reset during a stall with the buffer full
        idle();
        link(32'h600); wb(5'd8, 32'h88);
        tick();
        idle();
        bus.in_valid = 1'b1; bus.in_instr = mk(5'd0, 5'd8, 16'h0); bus.in_ctrl = 20'h9;
        bus.ex_valid = 1'b1; bus.ex_memread = 1'b1; bus.ex_rt = 5'd8;
        Reset = 1'b1;
        #1 check("mr_stall", 64'(bus.stall_req), 64'd0);
        tick();
        check("mr_valid", 64'(bus.out_valid), 64'd0);
        check("mr_ctrl",  64'(bus.out_ctrl), 64'd0);
        check("mr_rt",    64'(bus.out_rt), 64'd0);
        check("mr_imm",   64'(bus.out_imm), 64'd0);
        Reset = 1'b0;
        idle();
        for (int i = 1; i < 32; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = mk(5'(i), 5'd0, 16'h0);
            tick();
            check($sformatf("mr_r%0d", i), 64'(bus.out_rs_data), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end
endmodule
`default_nettype wire
